// File: rtl/fault_monitor_pkg.sv
// Shared types and constants for the fault monitor and its expected-value shadow.
package fault_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Must match the latency of the delay stage being monitored.
   localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/fault_monitor_if.sv
// Bus between the delay-stage checker and whoever drives stimulus and reads results.
interface fault_monitor_if #(
   parameter int DATA_W = 4,
   parameter int SUM_W  = 5,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  run_len;
   logic [DATA_W-1:0] stim;
   logic [SUM_W-1:0]  sum;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  fault_cnt;
   logic              first_valid;
   logic [CNT_W-1:0]  first_idx;
   logic [SUM_W-1:0]  first_exp;
   logic [SUM_W-1:0]  first_got;

   modport master (
      output start, run_len, stim, sum,
      input  busy, done, fault_cnt, first_valid, first_idx, first_exp, first_got
   );

   modport slave (
      input  start, run_len, stim, sum,
      output busy, done, fault_cnt, first_valid, first_idx, first_exp, first_got
   );
endinterface

// File: rtl/fault_monitor_exp_delay.sv
// Shadow of the monitored delay stage: shifts every cycle regardless of checker state.
module exp_delay #(
   parameter int W     = 5,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] pipe_q [DEPTH];

   // Shift register, cleared by synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= {W{1'b0}};
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/fault_monitor.sv
// Compares a delay stage's output against a shadow of its input over a run of
// samples, counting mismatches and capturing the first one.
module fault_monitor
   import fault_monitor_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int SUM_W  = 5,
   parameter int CNT_W  = 8
) (
   input logic            glitched_clk,
   input logic            rst,
   fault_monitor_if.slave bus
);
   localparam int FILL_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PIPE_DEPTH - 1);

   state_e             state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   rl_q, rl_d;
   logic [CNT_W-1:0]   fault_q, fault_d;
   logic               fv_q, fv_d;
   logic [CNT_W-1:0]   fidx_q, fidx_d;
   logic [SUM_W-1:0]   fexp_q, fexp_d;
   logic [SUM_W-1:0]   fgot_q, fgot_d;
   logic               busy_q, done_q;
   logic [DATA_W-1:0]  stim_s;
   logic [SUM_W-1:0]   exp_s;
   logic               mismatch_s;

   assign stim_s = bus.stim;

   exp_delay #(.W(SUM_W), .DEPTH(PIPE_DEPTH)) u_exp_delay (
      .clk_i  (glitched_clk),
      .rst_ni (rst),
      .d_i    (SUM_W'(stim_s)),
      .q_o    (exp_s)
   );

   assign mismatch_s = (state_q == RUN) && (bus.sum != exp_s);

   // Next-state and result-capture logic.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      rl_d    = rl_q;
      fault_d = fault_q;
      fv_d    = fv_q;
      fidx_d  = fidx_q;
      fexp_d  = fexp_q;
      fgot_d  = fgot_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = FILL;
               rl_d    = bus.run_len;
               fill_d  = {FILL_W{1'b0}};
               idx_d   = {CNT_W{1'b0}};
               fault_d = {CNT_W{1'b0}};
               fv_d    = 1'b0;
               fidx_d  = {CNT_W{1'b0}};
               fexp_d  = {SUM_W{1'b0}};
               fgot_d  = {SUM_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         FILL: begin
            if (fill_q == FILL_LAST) begin
               state_d = (rl_q == {CNT_W{1'b0}}) ? DONE : RUN;
            end else begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
         RUN: begin
            idx_d = idx_q + CNT_W'(1);
            if (mismatch_s) begin
               fault_d = (fault_q != {CNT_W{1'b1}}) ? fault_q + CNT_W'(1) : fault_q;
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fidx_d = idx_q;
                  fexp_d = exp_s;
                  fgot_d = bus.sum;
               end else begin
                  fv_d = fv_q;
               end
            end else begin
               fault_d = fault_q;
            end
            // rl_q is non-zero here: FILL diverts run_len=0 straight to DONE.
            if (idx_q == rl_q - CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge glitched_clk) begin
      if (!rst) begin
         state_q <= IDLE;
         fill_q  <= {FILL_W{1'b0}};
         idx_q   <= {CNT_W{1'b0}};
         rl_q    <= {CNT_W{1'b0}};
         fault_q <= {CNT_W{1'b0}};
         fv_q    <= 1'b0;
         fidx_q  <= {CNT_W{1'b0}};
         fexp_q  <= {SUM_W{1'b0}};
         fgot_q  <= {SUM_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         rl_q    <= rl_d;
         fault_q <= fault_d;
         fv_q    <= fv_d;
         fidx_q  <= fidx_d;
         fexp_q  <= fexp_d;
         fgot_q  <= fgot_d;
         busy_q  <= (state_d == FILL) || (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fault_cnt   = fault_q;
   assign bus.first_valid = fv_q;
   assign bus.first_idx   = fidx_q;
   assign bus.first_exp   = fexp_q;
   assign bus.first_got   = fgot_q;
endmodule

// File: tb/tb_fault_monitor.sv
// Directed plus randomized bench for fault_monitor with a sample-history reference model.
module tb_fault_monitor;
   logic glitched_clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   int   n;
   int   stim_base;
   bit   stim_incr;
   logic [3:0] hist    [0:4095];
   logic [4:0] sum_arr [0:4095];

   fault_monitor_if #(.DATA_W(4), .SUM_W(5), .CNT_W(4)) bus ();

   fault_monitor #(.DATA_W(4), .SUM_W(5), .CNT_W(4)) dut (
      .glitched_clk (glitched_clk),
      .rst          (rst),
      .bus          (bus)
   );

   initial glitched_clk = 1'b0;
   always #5 glitched_clk = ~glitched_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drives one cycle of inputs (fk: 0 clean, 1 force 5'h1F, 2 corrupt) and
   // returns at the next falling edge with outputs reflecting that cycle.
   task automatic next_cycle(input logic st, input logic [3:0] rl, input logic rs, input int fk);
      logic [3:0] s;
      logic [4:0] nom;
      s = stim_incr ? 4'(n - stim_base) : 4'($urandom);
      bus.start   = st;
      bus.run_len = rl;
      bus.stim    = s;
      rst         = rs;
      hist[n]     = rs ? s : 4'd0;
      if (!rs && n >= 1) hist[n-1] = 4'd0;
      nom = (n >= 2) ? {1'b0, hist[n-2]} : 5'd0;
      if (fk == 1) bus.sum = 5'h1F;
      else if (fk == 2) bus.sum = nom ^ 5'($urandom_range(31, 1));
      else bus.sum = nom;
      sum_arr[n] = bus.sum;
      n = n + 1;
      @(negedge glitched_clk);
   endtask

   task automatic do_run(input int rl, input int fmode, input bit ign);
      int n0, busy_cnt, k, fk, ef, fidx;
      bit got_done, st;
      logic [4:0] fe, fg, ex;
      n0 = n;
      stim_base = n0 + 1;
      next_cycle(1'b1, 4'(rl), 1'b1, 0);
      check("clr_fault_cnt", bus.fault_cnt, 0);
      check("clr_first_valid", bus.first_valid, 0);
      check("busy_on_start", bus.busy, 1);
      busy_cnt = 1;
      got_done = 1'b0;
      for (int c = 0; c < rl + 8 && !got_done; c++) begin
         k = n - (n0 + 3);
         fk = 0;
         if (k >= 0 && k < rl) begin
            case (fmode)
               1: fk = (k == 3) ? 1 : 0;
               2: fk = 2;
               3: fk = ($urandom_range(3, 0) == 0) ? 2 : 0;
               6: fk = (k % 2 == 0 && k < 6) ? 2 : 0;
               default: fk = 0;
            endcase
         end
         st = ign && rl >= 3 && (c == 0 || c == 4);
         next_cycle(st, 4'($urandom), 1'b1, fk);
         if (bus.busy) busy_cnt++;
         if (bus.done) got_done = 1'b1;
      end
      check("done_seen", got_done, 1);
      check("busy_len", busy_cnt, rl + 2);
      ef = 0; fidx = -1; fe = 5'd0; fg = 5'd0;
      for (int j = 0; j < rl; j++) begin
         ex = {1'b0, hist[n0 + 1 + j]};
         if (sum_arr[n0 + 3 + j] !== ex) begin
            if (ef < 15) ef++;
            if (fidx < 0) begin
               fidx = j; fe = ex; fg = sum_arr[n0 + 3 + j];
            end
         end
      end
      check("fault_cnt", bus.fault_cnt, ef);
      check("first_valid", bus.first_valid, (fidx >= 0) ? 1 : 0);
      check("first_idx", bus.first_idx, (fidx >= 0) ? fidx : 0);
      check("first_exp", bus.first_exp, fe);
      check("first_got", bus.first_got, fg);
      next_cycle(1'b0, 4'($urandom), 1'b1, 0);
      check("done_hold", bus.done, 1);
      check("fault_cnt_hold", bus.fault_cnt, ef);
   endtask

   initial begin
      int n0, k;
      pass_cnt  = 0;
      total_cnt = 0;
      n         = 0;
      stim_base = 0;
      stim_incr = 1'b0;
      bus.start = 1'b0; bus.run_len = 4'd0; bus.stim = 4'd0; bus.sum = 5'd0; rst = 1'b0;

      for (int i = 0; i < 3; i++) next_cycle(1'b0, 4'd0, 1'b0, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_fault_cnt", bus.fault_cnt, 0);
      check("rst_first_valid", bus.first_valid, 0);
      check("rst_first_idx", bus.first_idx, 0);
      check("rst_first_exp", bus.first_exp, 0);
      check("rst_first_got", bus.first_got, 0);
      for (int i = 0; i < 2; i++) next_cycle(1'b0, 4'd5, 1'b1, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);

      stim_incr = 1'b1;
      do_run(8, 0, 1'b0);
      do_run(8, 1, 1'b0);
      check("single_first_idx", bus.first_idx, 3);
      check("single_first_exp", bus.first_exp, 5'h03);
      check("single_first_got", bus.first_got, 5'h1F);
      check("single_fault_cnt", bus.fault_cnt, 1);

      stim_incr = 1'b0;
      do_run(15, 2, 1'b0);
      check("sat_fault_cnt", bus.fault_cnt, 15);
      check("sat_first_idx", bus.first_idx, 0);
      do_run(0, 0, 1'b0);
      check("zero_len_fault_cnt", bus.fault_cnt, 0);

      do_run(8, 6, 1'b0);
      check("three_faults", bus.fault_cnt, 3);
      do_run(10, 0, 1'b1);

      for (int r = 0; r < 12; r++) do_run($urandom_range(15, 0), 3, 1'($urandom));

      n0 = n;
      next_cycle(1'b1, 4'd10, 1'b1, 0);
      k = n - (n0 + 3);
      for (int c = 0; c < 10 && k < 4; c++) begin
         next_cycle((c == 0 || c == 3), 4'd2, 1'b1, (k == 1 || k == 2) ? 2 : 0);
         k = n - (n0 + 3);
      end
      check("mid_busy", bus.busy, 1);
      check("mid_fault_cnt", bus.fault_cnt, 2);
      check("mid_first_idx", bus.first_idx, 1);
      next_cycle(1'b0, 4'd0, 1'b0, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_fault_cnt", bus.fault_cnt, 0);
      check("mid_rst_first_valid", bus.first_valid, 0);
      check("mid_rst_first_idx", bus.first_idx, 0);
      check("mid_rst_first_exp", bus.first_exp, 0);
      check("mid_rst_first_got", bus.first_got, 0);
      next_cycle(1'b0, 4'd7, 1'b1, 0);
      check("post_rst_idle_busy", bus.busy, 0);
      check("post_rst_idle_done", bus.done, 0);
      do_run(5, 3, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/fault_monitor.md
FAULT_MONITOR -- requirements
Module: fault_monitor

Interface
REQ-001 Parameter DATA_W, default 4, stimulus width fed to the delay stage under test, SHALL be supported.
REQ-002 Parameter SUM_W, default 5, width of the stage output checked, SHALL be at least DATA_W.
REQ-003 Parameter CNT_W, default 8, width of sample, fault and run-length counters, SHALL be supported.
REQ-004 glitched_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  single-cycle pulse that begins a check run.
REQ-007 run_len  in  CNT_W  number of samples to compare; sampled on accepted start.
REQ-008 stim  in  DATA_W  the same value driven into the delay stage's a input this cycle.
REQ-009 sum  in  SUM_W  output of the delay stage.
REQ-010 busy  out  1  high in FILL and RUN.
REQ-011 done  out  1  high in DONE.
REQ-012 fault_cnt  out  CNT_W  mismatches seen in the current or last run.
REQ-013 first_valid  out  1  at least one mismatch recorded since the last accepted start.
REQ-014 first_idx  out  CNT_W  sample index (0-based) of the first mismatch.
REQ-015 first_exp / first_got  out  SUM_W each  expected and received values at the first mismatch.

Function
REQ-016 Expected value SHALL be stim zero-extended to SUM_W, delayed exactly 2 cycles by an internal 2-deep shadow pipeline that shifts every cycle, independent of state.
REQ-017 FSM states SHALL be IDLE, FILL, RUN, DONE.
REQ-018 IDLE: start=1 -> FILL; latch run_len; clear fault_cnt, sample index, first_* outputs.
REQ-019 FILL SHALL last exactly 2 cycles with no comparison, then go to RUN, or to DONE if latched run_len=0.
REQ-020 RUN: each cycle compare sum against expected, increment sample index; after compare with index=run_len-1 -> DONE.
REQ-021 On mismatch: fault_cnt increments, saturating at 2^CNT_W-1 with no wrap.
REQ-022 On mismatch with first_valid=0: capture first_idx, first_exp, first_got and set first_valid; later mismatches SHALL NOT overwrite.
REQ-023 DONE SHALL hold all results stable; start=1 in DONE behaves as in IDLE (clear and go to FILL).
REQ-024 start while in FILL or RUN SHALL be ignored, with run_len not relatched.
REQ-025 Mismatch on the last RUN sample SHALL be counted before done asserts; done rises the cycle after that compare.
REQ-026 Outputs SHALL be registered; there is no combinational path from sum to any output.

Reset
REQ-027 rst=0 at any clock edge, including mid-run, SHALL force IDLE; clear the shadow pipeline, counters, latched run_len and first_*; and drive busy=0, done=0, fault_cnt=0, first_valid=0, first_idx=0, first_exp=0, first_got=0.
REQ-028 The first clock with rst=1 SHALL be a normal IDLE cycle; no run starts without start.

Structure
REQ-029 A shared package SHALL hold the state enum type (IDLE, FILL, RUN, DONE) and the PIPE_DEPTH=2 constant matching the delay stage.
REQ-030 The 2-deep expected-value shadow SHALL be a sub-module named exp_delay, parameterised by width and PIPE_DEPTH.

Verification
REQ-031 Fault-free run: stim=0..9 incrementing, clean clock, start with run_len=8 -> busy for 10 cycles, done, fault_cnt=0, first_valid=0.
REQ-032 Single fault: force sum=5'h1F at RUN sample 3 where expected=5'h03 -> fault_cnt=1, first_idx=3, first_exp=5'h03, first_got=5'h1F.
REQ-033 Saturation: CNT_W=4, run_len=15, sum forced wrong every sample -> fault_cnt=15; first_idx=0 retained.
REQ-034 run_len=0: start -> 2 FILL cycles, then done=1 with fault_cnt=0.
REQ-035 Reset mid-run: rst=0 at RUN sample 4 after 2 faults -> next cycle IDLE, all outputs 0; start in FILL or RUN ignored.
REQ-036 Restart from DONE: after a run with fault_cnt=3, start -> fault_cnt and first_valid cleared the next cycle, and the new run completes normally.
